// File: rtl/uart_fifo_ctrl.sv
// Pointer/flag controller for the UART RX/TX FIFOs; drives an external reg_file.
// Optional sticky overflow/underflow flags are built when UART_FIFO_ERR_FLAGS_EN is defined.
module uart_fifo_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr,
   input  logic                  i_rd,
   output logic                  o_w_en,
   output logic [ADDR_WIDTH-1:0] o_w_addr,
   output logic [ADDR_WIDTH-1:0] o_r_addr,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
`ifdef UART_FIFO_ERR_FLAGS_EN
   output logic [ADDR_WIDTH:0]   o_count,
   input  logic                  i_err_clr,
   output logic                  o_overflow,
   output logic                  o_underflow
`else
   output logic [ADDR_WIDTH:0]   o_count
`endif
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AF_THR   = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_THR   = (ADDR_WIDTH+1)'(AE_LEVEL);

   logic [ADDR_WIDTH:0] w_ptr;
   logic [ADDR_WIDTH:0] r_ptr;
   logic [ADDR_WIDTH:0] count;
   logic                wr_ok;
   logic                rd_ok;

   // A push while full is still accepted when a pop frees the head slot in the same cycle.
   always_comb begin
      count          = w_ptr - r_ptr;
      o_full         = (count == DEPTH);
      o_empty        = (count == '0);
      o_almost_full  = (count >= AF_THR);
      o_almost_empty = (count <= AE_THR);
      rd_ok          = i_rd & ~o_empty;
      wr_ok          = i_wr & (~o_full | rd_ok);
      o_w_en         = wr_ok;
      o_w_addr       = w_ptr[ADDR_WIDTH-1:0];
      o_r_addr       = r_ptr[ADDR_WIDTH-1:0];
      o_count        = count;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         w_ptr <= '0;
         r_ptr <= '0;
      end else begin
         if (wr_ok) w_ptr <= w_ptr + PTR_ONE;
         if (rd_ok) r_ptr <= r_ptr + PTR_ONE;
      end
   end

`ifdef UART_FIFO_ERR_FLAGS_EN
   // Sticky error flags; a new set event wins over a simultaneous clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (i_wr && o_full && !rd_ok) o_overflow <= 1'b1;
         else if (i_err_clr)           o_overflow <= 1'b0;
         if (i_rd && o_empty)          o_underflow <= 1'b1;
         else if (i_err_clr)           o_underflow <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl at ADDR_WIDTH=2.
module tb_uart_fifo_ctrl;

   localparam int AW = 2;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_wr;
   logic          i_rd;
   logic          o_w_en;
   logic [AW-1:0] o_w_addr;
   logic [AW-1:0] o_r_addr;
   logic          o_full;
   logic          o_empty;
   logic          o_almost_full;
   logic          o_almost_empty;
   logic [AW:0]   o_count;
`ifdef UART_FIFO_ERR_FLAGS_EN
   logic          i_err_clr;
   logic          o_overflow;
   logic          o_underflow;
`endif

   int checks = 0;
   int errors = 0;

   uart_fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_wr           (i_wr),
      .i_rd           (i_rd),
      .o_w_en         (o_w_en),
      .o_w_addr       (o_w_addr),
      .o_r_addr       (o_r_addr),
      .o_full         (o_full),
      .o_empty        (o_empty),
      .o_almost_full  (o_almost_full),
      .o_almost_empty (o_almost_empty),
`ifdef UART_FIFO_ERR_FLAGS_EN
      .o_count        (o_count),
      .i_err_clr      (i_err_clr),
      .o_overflow     (o_overflow),
      .o_underflow    (o_underflow)
`else
      .o_count        (o_count)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_count"}, 32'(o_count), 0);
      checkOutput({tag, "_empty"}, 32'(o_empty), 1);
      checkOutput({tag, "_full"},  32'(o_full), 0);
      checkOutput({tag, "_ae"},    32'(o_almost_empty), 1);
      checkOutput({tag, "_af"},    32'(o_almost_full), 0);
      checkOutput({tag, "_waddr"}, 32'(o_w_addr), 0);
      checkOutput({tag, "_raddr"}, 32'(o_r_addr), 0);
`ifdef UART_FIFO_ERR_FLAGS_EN
      checkOutput({tag, "_ovf"},   32'(o_overflow), 0);
      checkOutput({tag, "_unf"},   32'(o_underflow), 0);
`endif
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      i_rst_n = 1'b0;
      i_wr    = 1'b0;
      i_rd    = 1'b0;
`ifdef UART_FIFO_ERR_FLAGS_EN
      i_err_clr = 1'b0;
`endif
      #2;
      checkReset("rst");
      #6 i_rst_n = 1'b1;
      cyc();
      checkOutput("idle_wen", 32'(o_w_en), 0);

      // Fill four entries with no pops.
      for (int i = 0; i < 4; i++) begin
         i_wr = 1'b1;
         #1;
         checkOutput("push_wen",   32'(o_w_en), 1);
         checkOutput("push_waddr", 32'(o_w_addr), 32'(i));
         cyc();
         checkOutput("push_count", 32'(o_count), 32'(i + 1));
         checkOutput("push_af",    32'(o_almost_full), (i + 1 >= 3) ? 1 : 0);
         checkOutput("push_ae",    32'(o_almost_empty), (i + 1 <= 1) ? 1 : 0);
         checkOutput("push_full",  32'(o_full), (i == 3) ? 1 : 0);
      end

      // Push while full is ignored.
      #1;
      checkOutput("ovf_wen",   32'(o_w_en), 0);
      checkOutput("ovf_waddr", 32'(o_w_addr), 0);
      cyc();
      i_wr = 1'b0;
      checkOutput("ovf_count", 32'(o_count), 4);
      checkOutput("ovf_full",  32'(o_full), 1);
      checkOutput("ovf_waddr2", 32'(o_w_addr), 0);
`ifdef UART_FIFO_ERR_FLAGS_EN
      checkOutput("ovf_flag", 32'(o_overflow), 1);
      cyc();
      checkOutput("ovf_hold", 32'(o_overflow), 1);
      i_err_clr = 1'b1;
      cyc();
      i_err_clr = 1'b0;
      checkOutput("ovf_clr", 32'(o_overflow), 0);
`endif

      // Drain four entries.
      for (int i = 0; i < 4; i++) begin
         i_rd = 1'b1;
         #1;
         checkOutput("pop_raddr", 32'(o_r_addr), 32'(i));
         cyc();
         checkOutput("pop_count", 32'(o_count), 32'(3 - i));
         checkOutput("pop_empty", 32'(o_empty), (i == 3) ? 1 : 0);
      end

      // Extra pop while empty.
      cyc();
      i_rd = 1'b0;
      checkOutput("unf_raddr", 32'(o_r_addr), 0);
      checkOutput("unf_count", 32'(o_count), 0);
      checkOutput("unf_empty", 32'(o_empty), 1);
`ifdef UART_FIFO_ERR_FLAGS_EN
      checkOutput("unf_flag", 32'(o_underflow), 1);
      i_err_clr = 1'b1;
      cyc();
      i_err_clr = 1'b0;
      checkOutput("unf_clr", 32'(o_underflow), 0);
`endif

      // Simultaneous push/pop on empty: only the push lands.
      i_wr = 1'b1;
      i_rd = 1'b1;
      #1;
      checkOutput("se_wen", 32'(o_w_en), 1);
      cyc();
      i_wr = 1'b0;
      i_rd = 1'b0;
      checkOutput("se_count", 32'(o_count), 1);
      checkOutput("se_empty", 32'(o_empty), 0);
      checkOutput("se_raddr", 32'(o_r_addr), 0);
      checkOutput("se_waddr", 32'(o_w_addr), 1);
`ifdef UART_FIFO_ERR_FLAGS_EN
      i_err_clr = 1'b1;
      cyc();
      i_err_clr = 1'b0;
      checkOutput("se_unf_clr", 32'(o_underflow), 0);
`endif

      // Top up to full, then six simultaneous push/pop cycles across the wrap.
      i_wr = 1'b1;
      cyc();
      cyc();
      cyc();
      i_wr = 1'b0;
      checkOutput("sf_pre_full",  32'(o_full), 1);
      checkOutput("sf_pre_waddr", 32'(o_w_addr), 0);
      for (int k = 0; k < 6; k++) begin
         i_wr = 1'b1;
         i_rd = 1'b1;
         #1;
         checkOutput("sf_wen",   32'(o_w_en), 1);
         checkOutput("sf_waddr", 32'(o_w_addr), 32'(k % 4));
         checkOutput("sf_raddr", 32'(o_r_addr), 32'(k % 4));
         cyc();
         checkOutput("sf_full",  32'(o_full), 1);
         checkOutput("sf_count", 32'(o_count), 4);
      end
      i_wr = 1'b0;
      i_rd = 1'b0;
`ifdef UART_FIFO_ERR_FLAGS_EN
      checkOutput("sf_no_ovf", 32'(o_overflow), 0);
`endif

      // Down to three entries, then an asynchronous reset between edges.
      i_rd = 1'b1;
      cyc();
      i_rd = 1'b0;
      checkOutput("ar_pre_count", 32'(o_count), 3);
      checkOutput("ar_pre_raddr", 32'(o_r_addr), 3);
      #2 i_rst_n = 1'b0;
      #1;
      checkReset("arst");
      #1 i_rst_n = 1'b1;
      cyc();
      checkOutput("ar_post_count", 32'(o_count), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
